// File: rtl/genius_controller.sv
// Moore sequencing FSM for the Genius memory game: setup, FPGA playback, user entry,
// check, round advance and result display.
module genius_controller #(
  parameter int unsigned NEXT_GAP = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state_o
);

  // state      | meaning
  // INIT       | reset setup/round/divider and per-round counters
  // SETUP      | user chooses level; enter starts the game
  // PLAY_FPGA  | FPGA plays the sequence back
  // PLAY_USER  | user enters the sequence under a time limit
  // CHECK      | compare user sequence against the FPGA sequence
  // NEXT_ROUND | advance round, clear per-round counters for NEXT_GAP cycles
  // RESULT     | show result screen; enter returns to INIT
  typedef enum logic [2:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    PLAY_FPGA  = 3'd2,
    PLAY_USER  = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(NEXT_GAP - 1);

  state_t     state, state_nxt;
  logic       enter_q;
  logic       enter_p;
  logic [3:0] gap_cnt;

  assign enter_p = enter & ~enter_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= INIT;
      enter_q <= 1'b0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      enter_q <= enter;
      // Held at zero outside NEXT_ROUND so every entry starts a fresh count.
      gap_cnt <= (state == NEXT_ROUND) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    E4  = 1'b0;
    SEL = 1'b1;
    case (state)
      INIT: begin
        R1 = 1'b1;
        R2 = 1'b1;
        state_nxt = SETUP;
      end
      SETUP: begin
        E1 = 1'b1;
        if (enter_p) state_nxt = PLAY_FPGA;
      end
      PLAY_FPGA: begin
        E3 = 1'b1;
        if (end_FPGA) state_nxt = PLAY_USER;
      end
      PLAY_USER: begin
        E2 = 1'b1;
        if (end_User)      state_nxt = CHECK;
        else if (end_time) state_nxt = RESULT;
      end
      CHECK: begin
        state_nxt = (match && !win) ? NEXT_ROUND : RESULT;
      end
      NEXT_ROUND: begin
        R2 = 1'b1;
        E4 = (gap_cnt == 4'd0);
        if (gap_cnt == GAP_LAST) state_nxt = PLAY_FPGA;
      end
      RESULT: begin
        SEL = 1'b0;
        if (enter_p) state_nxt = INIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign state_o = state;

endmodule
